poly_deriv_ctrl: RTL and testbench
==================================

POLY_DERIV_CTRL -- requirements
Module: poly_deriv_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the signed width of coefficients and of x.
REQ-002 Parameter ACC_W, default 2*WIDTH, sets the signed width of derivative coefficients, accumulator and result.
REQ-003 clk  input  1  Sole clock; all state updates on rising edge.
REQ-004 rst  input  1  Reset, synchronous, active-high.
REQ-005 coef_we  input  1  Coefficient write strobe.
REQ-006 coef_addr  input  3  Coefficient index i (0..7).
REQ-007 coef_data  input  WIDTH  Signed coefficient a_i.
REQ-008 start  input  1  Request to evaluate p'(x).
REQ-009 x_in  input  WIDTH  Signed evaluation point, sampled with start.
REQ-010 degree  input  3  Polynomial degree n (0..7), sampled with start.
REQ-011 busy  output  1  High from the cycle after start is accepted until the DONE cycle inclusive.
REQ-012 done  output  1  One-cycle pulse; result is valid in that cycle.
REQ-013 result  output  ACC_W  Signed p'(x), held until the next accepted start.
REQ-014 ovf  output  1  Sticky overflow flag (see Configuration).

Function
REQ-015 Internal coefficient bank a[0..7] (WIDTH each) and derivative bank d[0..6] (ACC_W each); coef_we in IDLE writes a[coef_addr] <= coef_data at the next edge.
REQ-016 coef_we while busy is ignored; a[] stays unchanged.
REQ-017 FSM states: IDLE, DERIV, EVAL, DONE.
REQ-018 IDLE: start=1 latches x_in, degree; clears ovf; goes to DERIV if degree>0, else to DONE with result <= 0.
REQ-019 start while not in IDLE is ignored.
REQ-020 DERIV: one cycle per i = 1..n, in ascending order; d[i-1] <= sign-extended (i * a[i]), computed with a single shared multiplier; acc <= 0.
REQ-021 EVAL: one cycle per k = n-1 down to 0; acc <= (acc * x + d[k]), truncated two's-complement to ACC_W bits; one shared multiplier and one shared adder.
REQ-022 After the last EVAL step: go to DONE, result <= acc.
REQ-023 DONE: done=1 and busy=1 for one cycle; then go to IDLE.
REQ-024 Latency: with start sampled at edge T, done is high in cycle T+2n+1; for n=0, done is high in cycle T+1.
REQ-025 Back-to-back operation: start is accepted in the IDLE cycle immediately following DONE.

Reset
REQ-026 rst=1 at an edge forces IDLE; busy, done, result, ovf, acc, a[] and d[] go to 0 at that edge, including when rst arrives mid-DERIV or mid-EVAL.
REQ-027 rst has priority over start and coef_we in the same cycle.

Configuration
REQ-028 Macro POLY_DERIV_OVF_DETECT_EN defined: ovf is set when any DERIV product or EVAL result discarded significant bits on truncation to ACC_W.
REQ-029 With the macro defined, ovf stays set until the next accepted start or reset.
REQ-030 Macro POLY_DERIV_OVF_DETECT_EN undefined: ovf is tied to 0, no detection logic exists, and all other behaviour is identical.

Verification (WIDTH=8, ACC_W=16)
REQ-031 a = {1,2,3} (a0..a2), n=2, x=4, start at T -> done high at T+5 only, result = 26, busy high T+1..T+5.
REQ-032 a3 = -1, others 0, n=3, x=-2 -> result = -12 at T+7, ovf = 0.
REQ-033 n=0, any a[], x=5 -> done at T+1, result = 0.
REQ-034 All a = 127, n=7, x=127 -> ovf = 1 with POLY_DERIV_OVF_DETECT_EN, ovf = 0 without it; result equals the modulo-2^16 value.
REQ-035 rst asserted during EVAL -> next cycle busy=0, done=0, result=0; a[] reads back 0; a subsequent run with a1=5, n=1, x=9 yields result = 5.
REQ-036 start and coef_we pulsed while busy -> ignored; running result unchanged; a[] unchanged.

Source files
------------

// File: rtl/poly_deriv_ctrl.sv
// Polynomial derivative evaluator: computes p'(x) for p(x) = sum a_i * x^i, degree 0..7.
// The derivative coefficients are built first, one per cycle. The result is then evaluated
// by Horner's rule. A single multiplier and a single adder are shared across both phases.
// Optional build macro POLY_DERIV_OVF_DETECT_EN enables the sticky truncation-overflow flag.
// When the macro is undefined, ovf is tied low.
module poly_deriv_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 2 * WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    coef_we,
  input  logic [2:0]              coef_addr,
  input  logic signed [WIDTH-1:0] coef_data,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic [2:0]              degree,
  output logic                    busy,
  output logic                    done,
  output logic signed [ACC_W-1:0] result,
  output logic                    ovf
);

  localparam int unsigned PW = ACC_W + WIDTH;

  typedef enum logic [1:0] {StIdle, StDeriv, StEval, StDone} state_e;

  state_e                    state_q, state_d;
  logic [2:0]                cnt_q;
  logic [2:0]                deg_q;
  logic signed [WIDTH-1:0]   x_q;
  logic signed [WIDTH-1:0]   a_q [8];
  logic signed [ACC_W-1:0]   d_q [7];
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   result_q;

  logic signed [ACC_W-1:0]   mul_a;
  logic signed [WIDTH-1:0]   mul_b;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   d_sel;
  logic signed [PW:0]        eval_full;
  logic signed [ACC_W-1:0]   deriv_val;
  logic signed [ACC_W-1:0]   eval_val;

  // Shared multiplier: i * a[i] while deriving, acc * x while evaluating
  always_comb begin
    mul_a = acc_q;
    mul_b = x_q;
    if (state_q == StDeriv) begin
      mul_a = ACC_W'(a_q[cnt_q]);
      mul_b = WIDTH'(cnt_q);
    end
    prod = PW'(mul_a) * PW'(mul_b);
  end

  // Shared adder: Horner step acc * x + d[k], kept one bit wider to expose carry-out
  always_comb begin
    d_sel = '0;
    for (int k = 0; k < 7; k++) begin
      if (cnt_q == 3'(k)) d_sel = d_q[k];
    end
    eval_full = (PW+1)'(prod) + (PW+1)'(d_sel);
    deriv_val = prod[ACC_W-1:0];
    eval_val  = eval_full[ACC_W-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (degree != 3'd0) ? StDeriv : StDone;
      StDeriv: if (cnt_q == deg_q) state_d = StEval;
      StEval:  if (cnt_q == 3'd0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  assign result = result_q;

  // Datapath: coefficient bank, derivative bank, Horner accumulator and result
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      deg_q    <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      for (int k = 0; k < 8; k++) a_q[k] <= '0;
      for (int k = 0; k < 7; k++) d_q[k] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (coef_we) a_q[coef_addr] <= coef_data;
          if (start) begin
            x_q   <= x_in;
            deg_q <= degree;
            cnt_q <= 3'd1;
            if (degree == 3'd0) result_q <= '0;
          end
        end
        StDeriv: begin
          // cnt_q is i here; d[i-1] holds i * a[i]
          for (int k = 0; k < 7; k++) begin
            if (cnt_q == 3'(k + 1)) d_q[k] <= deriv_val;
          end
          acc_q <= '0;
          if (cnt_q == deg_q) cnt_q <= deg_q - 3'd1;
          else                cnt_q <= cnt_q + 3'd1;
        end
        StEval: begin
          // cnt_q is k here, counting down to 0
          acc_q <= eval_val;
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd0) result_q <= eval_val;
        end
        default: ;
      endcase
    end
  end

`ifdef POLY_DERIV_OVF_DETECT_EN
  logic ovf_q;
  logic deriv_ovf;
  logic eval_ovf;

  // Truncation is lossless only when every dropped bit equals the kept sign bit
  assign deriv_ovf = !((&prod[PW-1:ACC_W-1]) || !(|prod[PW-1:ACC_W-1]));
  assign eval_ovf  = !((&eval_full[PW:ACC_W-1]) || !(|eval_full[PW:ACC_W-1]));

  // Sticky overflow, cleared by reset or an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle:  if (start) ovf_q <= 1'b0;
        StDeriv: if (deriv_ovf) ovf_q <= 1'b1;
        StEval:  if (eval_ovf) ovf_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_hi;
  assign unused_hi = ^eval_full[PW:ACC_W];
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_poly_deriv_ctrl.sv
// Self-checking bench for poly_deriv_ctrl (WIDTH=8, ACC_W=16).
// The reference model evaluates p'(x) = sum i*a_i*x^(i-1) directly and reduces it modulo 2^16.
module tb_poly_deriv_ctrl;

  logic              clk = 1'b0;
  logic              rst;
  logic              coef_we;
  logic [2:0]        coef_addr;
  logic signed [7:0] coef_data;
  logic              start;
  logic signed [7:0] x_in;
  logic [2:0]        degree;
  logic              busy;
  logic              done;
  logic signed [15:0] result;
  logic              ovf;

`ifdef POLY_DERIV_OVF_DETECT_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  poly_deriv_ctrl #(.WIDTH(8), .ACC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .start     (start),
    .x_in      (x_in),
    .degree    (degree),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     passes = 0;
  int     mdl_a[8];
  longint last_res = 0;

  typedef struct {
    string          name;
    logic [7:0][7:0] a;      // a[j] is coefficient j
    int             x;
    int             n;
    longint         exp_res;
    bit             exp_ovf_det;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
  endtask

  function automatic longint wrap_acc(input longint v);
    longint m;
    m = v & 64'hFFFF;
    if (m >= 32768) m -= 65536;
    return m;
  endfunction

  function automatic longint model_res(input int n, input int x);
    longint s, xp;
    s  = 0;
    xp = 1;
    for (int i = 1; i <= n; i++) begin
      s  += longint'(i) * mdl_a[i] * xp;
      xp *= x;
    end
    return wrap_acc(s);
  endfunction

  // Overflow follows the evaluation order: derivative products, then each Horner step
  function automatic bit model_ovf(input int n, input int x);
    bit     o;
    longint acc, full, dk;
    o   = 1'b0;
    acc = 0;
    for (int k = n - 1; k >= 0; k--) begin
      dk = longint'(k + 1) * mdl_a[k + 1];
      if (dk != wrap_acc(dk)) o = 1'b1;
      full = acc * x + wrap_acc(dk);
      if (full != wrap_acc(full)) o = 1'b1;
      acc = wrap_acc(full);
    end
    return o;
  endfunction

  task automatic write_coef(input int idx, input int val);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 3'(idx);
    coef_data = 8'(val);
    @(negedge clk);
    coef_we   = 1'b0;
    mdl_a[idx] = val;
  endtask

  task automatic load_model();
    for (int j = 0; j < 8; j++) write_coef(j, mdl_a[j]);
  endtask

  // Starts a run; optionally pokes start/coef_we during the first busy cycle
  task automatic run_op(input string name, input int x, input int n, input longint exp_res,
                        input bit exp_ovf, input bit disturb);
    int lat;
    @(negedge clk);
    chk({name, "_idle_busy"}, longint'(busy), 0);
    chk({name, "_idle_done"}, longint'(done), 0);
    chk({name, "_held_result"}, longint'(result), last_res);
    start  = 1'b1;
    x_in   = 8'(x);
    degree = 3'(n);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      if (lat == 2) begin
        start   = 1'b0;
        coef_we = 1'b0;
      end
      chk({name, "_busy"}, longint'(busy), 1);
      if (disturb && lat == 1) begin
        start     = 1'b1;
        x_in      = -8'sd7;
        degree    = 3'd7;
        coef_we   = 1'b1;
        coef_addr = 3'd1;
        coef_data = 8'sd99;
      end
      @(negedge clk);
      lat++;
    end
    start   = 1'b0;
    coef_we = 1'b0;
    chk({name, "_done"}, longint'(done), 1);
    chk({name, "_latency"}, longint'(lat), longint'(2 * n + 1));
    chk({name, "_done_busy"}, longint'(busy), 1);
    chk({name, "_result"}, longint'(result), exp_res);
    chk({name, "_ovf"}, longint'(ovf), longint'(exp_ovf));
    last_res = exp_res;
  endtask

  initial begin
    rst = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    start = 1'b0; x_in = '0; degree = '0;
    for (int j = 0; j < 8; j++) mdl_a[j] = 0;

    tbl[0] = '{"req031", {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd2, 8'd1}, 4, 2, 26, 1'b0};
    tbl[1] = '{"all127", {8{8'd127}}, 127, 7, -29188, 1'b1};
    tbl[2] = '{"req032", {8'd0, 8'd0, 8'd0, 8'd0, 8'hFF, 8'd0, 8'd0, 8'd0}, -2, 3, -12, 1'b0};
    tbl[3] = '{"deg0", {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 5, 0, 0, 1'b0};
    tbl[4] = '{"sum_i", {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0}, 1, 7, 28, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_result", longint'(result), 0);
    chk("reset_ovf", longint'(ovf), 0);

    // Directed vectors
    for (int t = 0; t < 5; t++) begin
      for (int j = 0; j < 8; j++) mdl_a[j] = int'($signed(tbl[t].a[j]));
      load_model();
      run_op(tbl[t].name, tbl[t].x, tbl[t].n, tbl[t].exp_res, OvfEn & tbl[t].exp_ovf_det, 1'b0);
    end

    // start and coef_we while busy are ignored; the second run is back-to-back
    mdl_a = '{1, 2, 3, 0, 0, 0, 0, 0};
    load_model();
    run_op("busy_poke", 4, 2, 26, 1'b0, 1'b1);
    run_op("back2back", 4, 2, 26, 1'b0, 1'b0);

    // Reset in the middle of EVAL, with start and coef_we asserted alongside it
    mdl_a = '{0, 3, 4, 5, 6, 7, 8, 9};
    load_model();
    run_op("pre_rst", 2, 3, model_res(3, 2), 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; x_in = 8'sd2; degree = 3'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_eval_busy", longint'(busy), 1);
    rst = 1'b1; start = 1'b1; coef_we = 1'b1; coef_addr = 3'd2; coef_data = 8'sd50;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; coef_we = 1'b0;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_result", longint'(result), 0);
    chk("rst_ovf", longint'(ovf), 0);
    last_res = 0;
    for (int j = 0; j < 8; j++) mdl_a[j] = 0;
    run_op("rst_cleared_a", 1, 7, 0, 1'b0, 1'b0);
    write_coef(1, 5);
    run_op("after_rst", 9, 1, 5, 1'b0, 1'b0);

    // Randomized runs against the reference model
    for (int r = 0; r < 24; r++) begin
      int x, n;
      for (int j = 0; j < 8; j++) mdl_a[j] = int'($urandom_range(0, 255)) - 128;
      x = int'($urandom_range(0, 255)) - 128;
      n = int'($urandom_range(0, 7));
      load_model();
      run_op("rand", x, n, model_res(n, x), OvfEn & model_ovf(n, x), 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
